ysyx_25050147_lsu: RTL and testbench

Load/store unit between the execute stage and the load-extension stage of the NPC core. It accepts one memory operation per handshake and aligns store data and byte masks to the word bus. It runs a four-state request/response exchange with data memory, then right-aligns load data by byte offset. It presents the aligned word together with the untouched `funct3` to the downstream load-extension block, which applies byte/half/word sign or zero extension.

---
 rtl/ysyx_25050147_lsu_pkg.sv | 15 +
 rtl/ysyx_25050147_lsu_align.sv | 34 +++
 rtl/ysyx_25050147_lsu.sv | 139 +++++++++++++
 tb/tb_ysyx_25050147_lsu.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25050147_lsu_pkg.sv
// Shared definitions for the NPC load/store unit: FSM encoding and access-size codes.
package ysyx_25050147_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

endpackage

// File: rtl/ysyx_25050147_lsu_align.sv
// Byte-lane alignment for the LSU: store mask/data shift, load right-shift, misalignment detect.
module ysyx_25050147_lsu_align
  import ysyx_25050147_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_sh,
  output logic        misaligned
);

  logic [3:0] base;

  always_comb begin
    base = 4'b0000;
    case (op[1:0])
      SZ_B:    base = 4'b0001;
      SZ_H:    base = 4'b0011;
      SZ_W:    base = 4'b1111;
      default: base = 4'b0000;
    endcase
  end

  // Half masks at offset 3 lose their upper lane; the write is still issued.
  assign wmask      = base << off;
  assign wdata_sh   = wdata << {off, 3'b000};
  assign rdata_sh   = rdata >> {off, 3'b000};
  assign misaligned = ((op[1:0] == SZ_H) && off[0]) ||
                      ((op[1:0] == SZ_W) && (off != 2'b00));

endmodule

// File: rtl/ysyx_25050147_lsu.sv
// NPC load/store unit: IDLE/REQ/WAIT/RESP exchange with data memory, lane-aligned data.
// Optional misalignment trap enabled by defining YSYX_25050147_LSU_ALIGN_CHECK_EN.
module ysyx_25050147_lsu
  import ysyx_25050147_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_op,
  output logic        out_err
);

`ifdef YSYX_25050147_LSU_ALIGN_CHECK_EN
  localparam logic ALIGN_CHECK = 1'b1;
`else
  localparam logic ALIGN_CHECK = 1'b0;
`endif

  lsu_state_t  state, state_nx;
  logic        accept;
  logic        mis_chk;
  logic        wen_q;
  logic [1:0]  off_q;
  logic [2:0]  op_q;
  logic [31:0] mem_addr_q;
  logic        mem_wen_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wmask_q;
  logic [31:0] out_data_q;
  logic        err_q;

  logic [2:0]  al_op;
  logic [1:0]  al_off;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_mis;

  assign accept = (state == ST_IDLE) && in_valid;

  // One aligner serves both phases: live inputs while idle, captured offset afterwards.
  assign al_op  = (state == ST_IDLE) ? in_op : op_q;
  assign al_off = (state == ST_IDLE) ? in_addr[1:0] : off_q;

  ysyx_25050147_lsu_align u_align (
    .op         (al_op),
    .off        (al_off),
    .wdata      (in_wdata),
    .rdata      (mem_rdata),
    .wmask      (al_wmask),
    .wdata_sh   (al_wdata),
    .rdata_sh   (al_rdata),
    .misaligned (al_mis)
  );

  assign mis_chk = ALIGN_CHECK & al_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (in_valid)       state_nx = mis_chk ? ST_RESP : ST_REQ;
      ST_REQ:  if (mem_req_ready)  state_nx = ST_WAIT;
      ST_WAIT: if (mem_resp_valid) state_nx = ST_RESP;
      ST_RESP: if (out_ready)      state_nx = ST_IDLE;
      default:                     state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    out_valid     = 1'b0;
    case (state)
      ST_IDLE: in_ready      = 1'b1;
      ST_REQ:  mem_req_valid = 1'b1;
      ST_RESP: out_valid     = 1'b1;
      default: ;
    endcase
  end

  // Request fields are registered at accept so they stay frozen through REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q       <= 1'b0;
      off_q       <= 2'b00;
      op_q        <= 3'b000;
      mem_addr_q  <= 32'h0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= 32'h0;
      mem_wmask_q <= 4'b0000;
      out_data_q  <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        wen_q       <= in_wen;
        off_q       <= in_addr[1:0];
        op_q        <= in_op;
        mem_addr_q  <= {in_addr[31:2], 2'b00};
        mem_wen_q   <= in_wen;
        mem_wdata_q <= al_wdata;
        mem_wmask_q <= in_wen ? al_wmask : 4'b0000;
        err_q       <= mis_chk;
        if (mis_chk) out_data_q <= 32'h0;
      end
      if ((state == ST_WAIT) && mem_resp_valid)
        out_data_q <= wen_q ? 32'h0 : al_rdata;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wen   = mem_wen_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign out_data  = out_data_q;
  assign out_op    = op_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_ysyx_25050147_lsu.sv
// Scoreboard bench for ysyx_25050147_lsu: lane-level reference model, random memory/backpressure.
module tb_ysyx_25050147_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_wen;
  logic [2:0]  in_op;
  logic [31:0] in_addr, in_wdata;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_data;
  logic [2:0]  out_op;

  always #5 clk = ~clk;

  ysyx_25050147_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_op(in_op),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_op(out_op), .out_err(out_err)
  );

  typedef struct {
    logic        wen;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t req_q[$];
  txn_t out_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   mem_mode = 0;   // 0 always ready, 1 random ready + spurious responses, 2 stalled
  int   ordy_mode = 0;  // 0 always ready, 1 random, 2 held low
  bit   mem_fire = 0;
  logic [31:0] mem_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(logic wen, logic [2:0] op, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] rdata);
    txn_t t;
    t.wen = wen; t.op = op; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    return t;
  endfunction

  // Reference model: reason per byte lane rather than per shift.
  function automatic logic ref_mis(txn_t t);
`ifdef YSYX_25050147_LSU_ALIGN_CHECK_EN
    return (t.op[1:0] == 2'b01 && t.addr[0]) || (t.op[1:0] == 2'b10 && t.addr[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int nbytes(logic [2:0] op);
    case (op[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] ref_mask(txn_t t);
    logic [3:0] m = 4'b0000;
    int off = int'(t.addr[1:0]);
    for (int i = 0; i < 4; i++)
      if (t.wen && i >= off && i < off + nbytes(t.op)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] ref_wdata(txn_t t);
    logic [31:0] w = 32'h0;
    int off = int'(t.addr[1:0]);
    for (int i = 0; i < 4; i++)
      if (i >= off) w[8*i +: 8] = t.wdata[8*(i-off) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_rdata(txn_t t);
    logic [31:0] r = 32'h0;
    int off = int'(t.addr[1:0]);
    if (t.wen || ref_mis(t)) return 32'h0;
    for (int i = 0; i < 4; i++)
      if (i + off < 4) r[8*i +: 8] = t.rdata[8*(i+off) +: 8];
    return r;
  endfunction

  // Memory model: checks requests against the queue, answers one cycle after the handshake.
  initial begin
    txn_t e;
    bit prev_stall = 0;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_mask;
    logic        h_wen;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0; mem_fire = 0;
      end else if (mem_req_valid) begin
        if (prev_stall) begin
          chk("req_addr_stable", mem_addr, h_addr);
          chk("req_wen_stable", 32'(mem_wen), 32'(h_wen));
          chk("req_mask_stable", 32'(mem_wmask), 32'(h_mask));
          chk("req_wdata_stable", mem_wdata, h_wdata);
        end
        if (mem_req_ready) begin
          if (req_q.size() == 0) chk("req_expected", 32'd0, 32'd1);
          else begin
            e = req_q.pop_front();
            chk("mem_addr", mem_addr, {e.addr[31:2], 2'b00});
            chk("mem_wen", 32'(mem_wen), 32'(e.wen));
            chk("mem_wmask", 32'(mem_wmask), 32'(ref_mask(e)));
            if (e.wen) chk("mem_wdata", mem_wdata, ref_wdata(e));
            mem_rd = e.rdata;
            mem_fire = 1;
          end
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          h_addr = mem_addr; h_wen = mem_wen; h_mask = mem_wmask; h_wdata = mem_wdata;
        end
      end else prev_stall = 0;
      @(posedge clk); #1;
      if (mem_fire) begin
        mem_resp_valid = 1'b1; mem_rdata = mem_rd; mem_fire = 0;
      end else begin
        mem_resp_valid = (mem_mode != 0) && ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
      mem_req_ready = (mem_mode == 0) ? 1'b1 : (mem_mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = (ordy_mode == 0) ? 1'b1 : (ordy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: pops the scoreboard on every result handshake, checks hold under backpressure.
  initial begin
    txn_t e;
    bit ohold = 0;
    logic [31:0] hd;
    logic [2:0]  hop;
    logic        herr;
    forever begin
      @(negedge clk);
      if (!rst_n) ohold = 0;
      else if (out_valid) begin
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        if (ohold) begin
          chk("out_data_held", out_data, hd);
          chk("out_op_held", 32'(out_op), 32'(hop));
          chk("out_err_held", 32'(out_err), 32'(herr));
        end
        if (out_ready) begin
          if (out_q.size() == 0) chk("out_expected", 32'd0, 32'd1);
          else begin
            e = out_q.pop_front();
            chk("out_data", out_data, ref_rdata(e));
            chk("out_op", 32'(out_op), 32'(e.op));
            chk("out_err", 32'(out_err), 32'(ref_mis(e)));
          end
          ohold = 0;
        end else begin
          ohold = 1; hd = out_data; hop = out_op; herr = out_err;
        end
      end else ohold = 0;
    end
  end

  // Presents a transaction from a posedge+1 slot and returns at posedge+1 after the accept edge.
  task automatic issue(input txn_t t);
    bit ok = 0;
    in_valid = 1'b1; in_wen = t.wen; in_op = t.op; in_addr = t.addr; in_wdata = t.wdata;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (!ref_mis(t)) req_q.push_back(t);
        out_q.push_back(t);
        ok = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clk); #1;
      done = (out_q.size() == 0) && (req_q.size() == 0);
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic latency_check(input string name, input txn_t t);
    int lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
      @(posedge clk); #1;
    end
    // Normal path: REQ, WAIT, then RESP in the third cycle; trapped path: RESP immediately.
    chk(name, 32'(lat), ref_mis(t) ? 32'd0 : 32'd2);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_mem_wen"}, 32'(mem_wen), 32'd0);
    chk({tag, "_mem_wmask"}, 32'(mem_wmask), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_out_op"}, 32'(out_op), 32'd0);
    chk({tag, "_out_err"}, 32'(out_err), 32'd0);
  endtask

  initial begin
    txn_t t;
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; in_wen = 1'b0; in_op = 3'b000;
    in_addr = 32'h0; in_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Store byte into lane 3.
    t = mk(1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB, $urandom);
    issue(t);
    @(negedge clk);
    chk("sb_mem_addr", mem_addr, 32'h8000_0000);
    chk("sb_mem_wmask", 32'(mem_wmask), 32'h8);
    chk("sb_mem_wdata", mem_wdata, 32'hAB00_0000);
    drain();

    // Unsigned-half load from offset 2 with minimum latency.
    t = mk(1'b0, 3'b101, 32'h8000_0002, $urandom, 32'hBEEF_1234);
    issue(t);
    latency_check("lhu_latency", t);
    drain();

    // Memory holds off the request for three cycles.
    mem_mode = 2;
    issue(mk(1'b1, 3'b001, 32'h8000_0105, 32'h0000_5A5A, $urandom));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req_valid", 32'(mem_req_valid), 32'd1);
      chk("stall_out_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    mem_mode = 0;
    drain();

    // Downstream holds off the result for two cycles.
    ordy_mode = 2;
    @(posedge clk); #1;
    issue(mk(1'b0, 3'b010, 32'h8000_0200, $urandom, 32'hCAFE_F00D));
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
      if (!seen) begin @(posedge clk); #1; end
    end
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_out_valid_held", 32'(out_valid), 32'd1);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    ordy_mode = 0;
    drain();

    // A competing offer while busy must be ignored.
    issue(mk(1'b0, 3'b100, 32'h8000_0301, $urandom, 32'h1122_3344));
    in_valid = 1'b1; in_wen = 1'b1; in_op = 3'b010; in_addr = 32'h1234_5670; in_wdata = 32'hDEAD_BEEF;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid && out_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!seen) chk("ignore_timeout", 32'd0, 32'd1);
    drain();

    // Reset asserted while waiting for the memory response.
    issue(mk(1'b0, 3'b010, 32'h8000_0400, $urandom, $urandom));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    req_q.delete(); out_q.delete();
    mem_resp_valid = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(mk(1'b0, 3'b001, 32'h8000_0502, $urandom, 32'hA5A5_7E7E));
    drain();

    // Misaligned word accesses.
    t = mk(1'b0, 3'b010, 32'h8000_0001, $urandom, 32'h8765_4321);
    issue(t);
    latency_check("lw_mis_latency", t);
    drain();
    issue(mk(1'b1, 3'b010, 32'h8000_0001, 32'h0102_0304, $urandom));
    drain();

    // Randomized traffic under random memory and downstream backpressure.
    mem_mode = 1; ordy_mode = 1;
    for (int n = 0; n < 150; n++) begin
      issue(mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();
    mem_mode = 0; ordy_mode = 0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
